// File: rtl/paddle_array_if.sv
// Pixel stream from the paddle engine to the VGA arbiter.
// The source holds every field stable while oPlot is high and iPixReady is low.
interface paddle_array_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;
  logic [2:0]    oColour;
  logic          oPlot;
  logic          iPixReady;

  modport master (
    output oX, oY, oColour, oPlot,
    input  iPixReady
  );

  modport slave (
    input  oX, oY, oColour, oPlot,
    output iPixReady
  );
endinterface

// File: rtl/paddle_array.sv
// Multi-paddle engine: per-frame clamped Y update, then a stallable erase/draw stream.
// PADDLE_ACCEL_EN adds per-paddle hold acceleration (step = RATE << hold).
module paddle_array #(
  parameter int NUM_PADDLES      = 2,
  parameter int X_SCREEN_PIXELS  = 320,
  parameter int Y_SCREEN_PIXELS  = 240,
  parameter int X_PADDLE_SIZE    = 5,
  parameter int Y_PADDLE_SIZE    = 40,
  parameter int X_MARGIN         = 10,
  parameter int X_LANE_STEP      = 20,
  parameter int RATE             = 2,
  parameter int CLOCKS_PER_FRAME = 833333,
  parameter logic [2:0] PADDLE_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR     = 3'b000
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic [NUM_PADDLES-1:0] iUp,
  input  logic [NUM_PADDLES-1:0] iDown,
  paddle_array_if.master         pix_if,
  output logic                   oFrameDone,
  output logic                   oOverrun,
  output logic [NUM_PADDLES*($clog2(Y_SCREEN_PIXELS)+1)-1:0] oPaddleY
);
  localparam int XW   = $clog2(X_SCREEN_PIXELS) + 1;
  localparam int YW   = $clog2(Y_SCREEN_PIXELS) + 1;
  localparam int YMAX = Y_SCREEN_PIXELS - Y_PADDLE_SIZE;
  localparam int CW   = $clog2(CLOCKS_PER_FRAME + 1);
  localparam int IW   = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1;
  localparam int CXW  = $clog2(X_PADDLE_SIZE + 1);
  localparam int CYW  = $clog2(Y_PADDLE_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UPDATE, S_SCAN, S_ERASE, S_DRAW, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0]          r_frame_cnt;
  logic                   r_pend;
  logic                   r_ovr;
  logic                   r_first;
  logic [YW-1:0]          r_ypos [NUM_PADDLES];
  logic [YW-1:0]          r_yold [NUM_PADDLES];
  logic [YW-1:0]          w_ynew [NUM_PADDLES];
  logic [NUM_PADDLES-1:0] r_todo;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          w_sel;
  logic [CXW-1:0]         r_cx;
  logic [CYW-1:0]         r_cy;
  logic [XW-1:0]          r_x;
  logic [YW-1:0]          r_y;
  logic [2:0]             r_col;
  logic                   r_plot;
  logic                   w_tick;
  logic                   w_fire;
  logic                   w_last;
  logic                   w_row_end;

  function automatic logic [XW-1:0] f_px(input int i);
    int x;
    if (i % 2 == 0)
      x = X_MARGIN + (i / 2) * X_LANE_STEP;
    else
      x = X_SCREEN_PIXELS - X_MARGIN - X_PADDLE_SIZE
        - (i / 2) * X_LANE_STEP;
    return XW'(x);
  endfunction

  // Saturating move: a partial step up to either boundary is allowed.
  function automatic logic [YW-1:0] f_move(
    input logic [YW-1:0] y,
    input logic          up,
    input logic          dn,
    input int            step
  );
    int yi;
    yi = int'(y);
    if (up && !dn)
      yi = (yi > step) ? yi - step : 0;
    else if (dn && !up)
      yi = (yi + step < YMAX) ? yi + step : YMAX;
    return YW'(yi);
  endfunction

  assign w_tick    = (r_frame_cnt == '0);
  assign w_fire    = r_plot & pix_if.iPixReady;
  assign w_row_end = (r_cx == CXW'(X_PADDLE_SIZE - 1));
  assign w_last    = w_row_end && (r_cy == CYW'(Y_PADDLE_SIZE - 1));

`ifdef PADDLE_ACCEL_EN
  logic [1:0] r_hold [NUM_PADDLES];
  logic [1:0] w_hold [NUM_PADDLES];
  logic [1:0] r_pdir [NUM_PADDLES];

  always_comb begin
    for (int i = 0; i < NUM_PADDLES; i++) begin
      w_hold[i] = '0;
      if ((iUp[i] ^ iDown[i]) && ({iUp[i], iDown[i]} == r_pdir[i]))
        w_hold[i] = (r_hold[i] == 2'd3) ? 2'd3 : r_hold[i] + 2'd1;
      w_ynew[i] = f_move(r_ypos[i], iUp[i], iDown[i],
                         RATE << w_hold[i]);
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int i = 0; i < NUM_PADDLES; i++) begin
        r_hold[i] <= '0;
        r_pdir[i] <= '0;
      end
    end else if (r_state == S_UPDATE) begin
      for (int i = 0; i < NUM_PADDLES; i++) begin
        r_hold[i] <= w_hold[i];
        r_pdir[i] <= {iUp[i], iDown[i]};
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_PADDLES; i++)
      w_ynew[i] = f_move(r_ypos[i], iUp[i], iDown[i], RATE);
  end
`endif

  always_comb begin
    w_sel = '0;
    for (int i = NUM_PADDLES - 1; i >= 0; i--)
      if (r_todo[i]) w_sel = IW'(i);
  end

  always_ff @(posedge iClock) begin
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_tick || r_pend) w_next = S_UPDATE;
      S_UPDATE: w_next = S_SCAN;
      S_SCAN: begin
        if (r_todo == '0) w_next = S_DONE;
        else if (r_first) w_next = S_DRAW;
        else              w_next = S_ERASE;
      end
      S_ERASE:  if (w_fire && w_last) w_next = S_DRAW;
      S_DRAW:   if (w_fire && w_last) w_next = S_SCAN;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_frame_cnt <= CW'(CLOCKS_PER_FRAME - 1);
      r_pend      <= 1'b0;
      r_ovr       <= 1'b0;
      r_first     <= 1'b1;
      r_todo      <= '0;
      r_idx       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_col       <= BG_COLOUR;
      r_plot      <= 1'b0;
      for (int i = 0; i < NUM_PADDLES; i++) begin
        r_ypos[i] <= YW'(YMAX / 2);
        r_yold[i] <= YW'(YMAX / 2);
      end
    end else begin
      r_frame_cnt <= w_tick ? CW'(CLOCKS_PER_FRAME - 1)
                            : r_frame_cnt - CW'(1);
      r_ovr <= 1'b0;
      // One tick may wait while busy; a second one is dropped.
      if (r_state == S_IDLE) begin
        if (r_pend) r_pend <= w_tick;
      end else if (w_tick) begin
        if (r_pend) r_ovr  <= 1'b1;
        else        r_pend <= 1'b1;
      end

      if (r_state == S_UPDATE) begin
        for (int i = 0; i < NUM_PADDLES; i++) begin
          r_yold[i] <= r_ypos[i];
          r_ypos[i] <= w_ynew[i];
          r_todo[i] <= (w_ynew[i] != r_ypos[i]) | r_first;
        end
      end

      if (r_state == S_SCAN && r_todo != '0) begin
        r_idx         <= w_sel;
        r_todo[w_sel] <= 1'b0;
        r_cx          <= '0;
        r_cy          <= '0;
        r_x           <= f_px(int'(w_sel));
        r_plot        <= 1'b1;
        if (r_first) begin
          r_y   <= r_ypos[w_sel];
          r_col <= PADDLE_COLOUR;
        end else begin
          r_y   <= r_yold[w_sel];
          r_col <= BG_COLOUR;
        end
      end

      if (w_fire) begin
        if (w_last) begin
          r_cx <= '0;
          r_cy <= '0;
          if (r_state == S_ERASE) begin
            r_x   <= f_px(int'(r_idx));
            r_y   <= r_ypos[r_idx];
            r_col <= PADDLE_COLOUR;
          end else begin
            r_plot <= 1'b0;
          end
        end else if (w_row_end) begin
          r_cx <= '0;
          r_cy <= r_cy + CYW'(1);
          r_x  <= f_px(int'(r_idx));
          r_y  <= r_y + YW'(1);
        end else begin
          r_cx <= r_cx + CXW'(1);
          r_x  <= r_x + XW'(1);
        end
      end

      if (r_state == S_DONE) r_first <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_py
    assign oPaddleY[g*YW +: YW] = r_ypos[g];
  end

  assign pix_if.oX       = r_x;
  assign pix_if.oY       = r_y;
  assign pix_if.oColour  = r_col;
  assign pix_if.oPlot    = r_plot;
  assign oFrameDone      = (r_state == S_DONE);
  assign oOverrun        = r_ovr;
endmodule

// File: tb/tb_paddle_array.sv
// Bench for paddle_array: frame-level pixel model plus directed literal checks.
// RATE=3 so clamping exercises partial steps at both boundaries.
module tb_paddle_array;
  localparam int CPF = 1000;
  localparam int RATE = 3;
  localparam int N = 2;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int XP = 5;
  localparam int YP = 40;
  localparam int YMAX = 200;

  logic iClock = 1'b0;
  logic iReset = 1'b1;
  logic [N-1:0] iUp = '0;
  logic [N-1:0] iDown = '0;
  logic oFrameDone, oOverrun;
  logic [N*YW-1:0] oPaddleY;
  logic rdy = 1'b1;

  paddle_array_if #(.XW(XW), .YW(YW)) pif ();
  assign pif.iPixReady = rdy;

  paddle_array #(
    .NUM_PADDLES(N),
    .RATE(RATE),
    .CLOCKS_PER_FRAME(CPF)
  ) dut (
    .iClock(iClock),
    .iReset(iReset),
    .iUp(iUp),
    .iDown(iDown),
    .pix_if(pif),
    .oFrameDone(oFrameDone),
    .oOverrun(oOverrun),
    .oPaddleY(oPaddleY)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    bit mark;
    int x;
    int y;
    int c;
  } px_t;

  px_t q[$];
  int my[N];
  bit mfirst;
  int vectors = 0;
  int miscompares = 0;
  int pix_cnt = 0;
  int last_pix = 0;
  int ovr_cnt = 0;
  int done_cnt = 0;
  int fx, fy, fc;
  int rmode = 0;

  function automatic int px_x(input int i);
    if (i % 2 == 0) return 10 + (i / 2) * 20;
    return 320 - 10 - 5 - (i / 2) * 20;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < N; i++) my[i] = YMAX / 2;
    mfirst = 1'b1;
  endfunction

  function automatic void push_rect(input int i, input int y0,
                                    input int c);
    px_t p;
    for (int r = 0; r < YP; r++)
      for (int k = 0; k < XP; k++) begin
        p.mark = 1'b0;
        p.x = px_x(i) + k;
        p.y = y0 + r;
        p.c = c;
        q.push_back(p);
      end
  endfunction

  function automatic void model_frame(input logic [N-1:0] up,
                                      input logic [N-1:0] dn);
    px_t p;
    int old;
    for (int i = 0; i < N; i++) begin
      old = my[i];
      if (up[i] && !dn[i]) my[i] = (old - RATE < 0) ? 0 : old - RATE;
      if (dn[i] && !up[i])
        my[i] = (old + RATE > YMAX) ? YMAX : old + RATE;
      if (my[i] != old || mfirst) begin
        if (!mfirst) push_rect(i, old, 0);
        push_rect(i, my[i], 7);
      end
    end
    p.mark = 1'b1;
    p.x = 0;
    p.y = 0;
    p.c = 0;
    q.push_back(p);
    mfirst = 1'b0;
  endfunction

  always @(posedge iClock) begin
    #1;
    case (rmode)
      0: rdy = 1'b1;
      1: rdy = ($urandom_range(0, 99) < 30);
      default: rdy = 1'b0;
    endcase
  end

  logic pstall = 1'b0;
  int sx, sy, sc;

  always @(negedge iClock) begin
    if (iReset) begin
      pstall = 1'b0;
      pix_cnt = 0;
    end else begin
      if (pstall) begin
        vectors++;
        if (!(pif.oPlot && int'(pif.oX) == sx && int'(pif.oY) == sy
              && int'(pif.oColour) == sc)) begin
          miscompares++;
          $display("FAIL stall_hold: got plot=%0b (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                   pif.oPlot, pif.oX, pif.oY, pif.oColour, sx, sy, sc);
        end
      end
      if (pif.oPlot && rdy) begin
        vectors++;
        if (q.size() == 0 || q[0].mark) begin
          miscompares++;
          $display("FAIL pixel_extra: got (%0d,%0d,%0d) required none",
                   pif.oX, pif.oY, pif.oColour);
        end else begin
          if (int'(pif.oX) != q[0].x || int'(pif.oY) != q[0].y
              || int'(pif.oColour) != q[0].c) begin
            miscompares++;
            $display("FAIL pixel: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     pif.oX, pif.oY, pif.oColour, q[0].x, q[0].y, q[0].c);
          end
          void'(q.pop_front());
        end
        if (pix_cnt == 0) begin
          fx = int'(pif.oX);
          fy = int'(pif.oY);
          fc = int'(pif.oColour);
        end
        pix_cnt++;
      end
      if (oFrameDone) begin
        vectors++;
        if (q.size() == 0 || !q[0].mark) begin
          miscompares++;
          $display("FAIL frame_end: got done with %0d model entries pending, required 0",
                   q.size());
          while (q.size() > 0 && !q[0].mark) void'(q.pop_front());
        end
        if (q.size() > 0) void'(q.pop_front());
        for (int i = 0; i < N; i++) begin
          vectors++;
          if (int'(oPaddleY[i*YW +: YW]) != my[i]) begin
            miscompares++;
            $display("FAIL paddle_y%0d: got %0d required %0d",
                     i, oPaddleY[i*YW +: YW], my[i]);
          end
        end
        last_pix = pix_cnt;
        pix_cnt = 0;
        done_cnt++;
      end
      if (oOverrun) ovr_cnt++;
      pstall = pif.oPlot && !rdy;
      sx = int'(pif.oX);
      sy = int'(pif.oY);
      sc = int'(pif.oColour);
    end
  end

  task automatic finish_sim();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  endtask

  task automatic wait_done(input int limit, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge iClock);
      n++;
    end while (!oFrameDone && n < limit);
    if (!oFrameDone) begin
      check({nm, "_timeout"}, n, -1);
      finish_sim();
    end
    #1;
  endtask

  task automatic do_frame(input logic [N-1:0] up, input logic [N-1:0] dn,
                          input int limit, input string nm);
    iUp = up;
    iDown = dn;
    model_frame(up, dn);
    wait_done(limit, nm);
  endtask

  function automatic int py(input int i);
    return int'(oPaddleY[i*YW +: YW]);
  endfunction

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge iClock);
    @(negedge iClock);
    check("rst_plot", int'(pif.oPlot), 0);
    check("rst_done", int'(oFrameDone), 0);
    check("rst_ovr", int'(oOverrun), 0);
    check("rst_x", int'(pif.oX), 0);
    check("rst_y", int'(pif.oY), 0);
    check("rst_col", int'(pif.oColour), 0);
    check("rst_y0", py(0), 100);
    check("rst_y1", py(1), 100);
    @(posedge iClock);
    #1 iReset = 1'b0;

    do_frame(2'b00, 2'b00, 3000, "first");
    check("first_pix", last_pix, 400);
    check("first_x", fx, 10);
    check("first_y", fy, 100);
    check("first_c", fc, 7);
    check("first_done_cnt", done_cnt, 1);

    do_frame(2'b01, 2'b10, 3000, "move");
    check("move_pix", last_pix, 800);
    check("move_y0", py(0), 97);
    check("move_y1", py(1), 103);
    check("move_erase_y", fy, 100);
    check("move_erase_c", fc, 0);

    for (int k = 0; k < 32; k++) do_frame(2'b01, 2'b10, 3000, "walk");
    check("near_y0", py(0), 1);
    check("near_y1", py(1), 199);

    do_frame(2'b01, 2'b10, 3000, "clamp");
    check("clamp_y0", py(0), 0);
    check("clamp_y1", py(1), 200);
    check("clamp_pix", last_pix, 800);

    do_frame(2'b01, 2'b10, 3000, "held");
    check("held_pix", last_pix, 0);
    check("held_y0", py(0), 0);

    do_frame(2'b11, 2'b11, 3000, "both");
    check("both_pix", last_pix, 0);
    check("both_y1", py(1), 200);

    rmode = 1;
    for (int k = 0; k < 3; k++) begin
      do_frame(2'b10, 2'b01, 6000, "rand");
      check("rand_pix", last_pix, 800);
    end
    check("rand_y0", py(0), 9);
    check("rand_y1", py(1), 191);

    rmode = 2;
    ovr_cnt = 0;
    iUp = 2'b01;
    iDown = 2'b00;
    model_frame(2'b01, 2'b00);
    n = 0;
    while (ovr_cnt == 0 && n < 4000) begin
      @(negedge iClock);
      n++;
    end
    #1;
    if (ovr_cnt == 0) begin
      check("ovr_timeout", n, -1);
      finish_sim();
    end
    rmode = 0;
    wait_done(3000, "stall");
    check("stall_pix", last_pix, 400);
    check("stall_ovr", ovr_cnt, 1);
    do_frame(2'b00, 2'b00, 20, "pending");
    check("pending_pix", last_pix, 0);
    check("pending_ovr", ovr_cnt, 1);

    iUp = 2'b01;
    model_frame(2'b01, 2'b00);
    n = 0;
    while (!(pif.oPlot && pif.oColour == 3'b111) && n < 3000) begin
      @(negedge iClock);
      n++;
    end
    if (n >= 3000) begin
      check("draw_timeout", n, -1);
      finish_sim();
    end
    @(posedge iClock);
    #1 iReset = 1'b1;
    model_reset();
    @(negedge iClock);
    @(negedge iClock);
    check("midrst_plot", int'(pif.oPlot), 0);
    check("midrst_y0", py(0), 100);
    check("midrst_y1", py(1), 100);
    @(posedge iClock);
    #1 iReset = 1'b0;

    do_frame(2'b00, 2'b00, 3000, "refirst");
    check("refirst_pix", last_pix, 400);
    check("refirst_x", fx, 10);
    check("refirst_c", fc, 7);

    finish_sim();
  end
endmodule
